// File: rtl/timecode_memory_reader.sv
// timecode_memory_reader
//
// Fetches one timecode frame of FRAME_BYTES consecutive bytes from the
// timecode memory, starting at base_addr, and streams the bytes in order to
// the LTC serializer over a valid/ready interface. Exactly one memory read
// is outstanding at a time: a byte is read, presented, handed off, and only
// then is the next read issued, so read latency and stream backpressure
// never overlap.
//
// Optional feature (compile-time macro TC_READER_SYNC_WORD_EN):
//   when defined, two extra stream bytes 0x3F then 0xFD (LTC sync word)
//   follow the last memory byte, each after a one-cycle gap, with tc_last
//   on 0xFD only. No memory reads are issued for them.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   start          one-cycle frame request, honoured only while busy=0
//   base_addr      first frame address, sampled on an accepted start
//   busy           frame read in progress
//   done           one-cycle pulse after the final byte handshake
//   mem_rd_en      memory read strobe (one cycle per byte)
//   mem_addr       memory read address, holds its last value between reads
//   mem_rd_data    memory data, valid RD_LAT cycles after the mem_rd_en cycle
//   tc_data        stream byte
//   tc_valid       stream byte valid
//   tc_ready       downstream accepts byte
//   tc_last        final byte of the frame, qualified by tc_valid
//
// Parameters: ADDR_W, DATA_W, FRAME_BYTES (1..255), RD_LAT (1..4).

module timecode_memory_reader #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int FRAME_BYTES = 10,
  parameter int RD_LAT      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] tc_data,
  output logic              tc_valid,
  input  logic              tc_ready,
  output logic              tc_last
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PRESENT,
    S_GAP
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(FRAME_BYTES - 1);
  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  state_t            state_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [7:0]        index_reg;
  logic [2:0]        lat_cnt_reg;

`ifdef TC_READER_SYNC_WORD_EN
  localparam logic [DATA_W-1:0] SYNC_FIRST  = DATA_W'(8'h3F);
  localparam logic [DATA_W-1:0] SYNC_SECOND = DATA_W'(8'hFD);
  // 0: memory bytes, 1: first sync byte, 2: second sync byte
  logic [1:0] sync_phase_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      base_reg    <= '0;
      index_reg   <= '0;
      lat_cnt_reg <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      tc_data     <= '0;
      tc_valid    <= 1'b0;
      tc_last     <= 1'b0;
`ifdef TC_READER_SYNC_WORD_EN
      sync_phase_reg <= 2'd0;
`endif
    end else begin
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            base_reg  <= base_addr;
            index_reg <= '0;
            busy      <= 1'b1;
            // strobe and address are registered, so they go out while ISSUE
            mem_rd_en <= 1'b1;
            mem_addr  <= base_addr;
            state_reg <= S_ISSUE;
`ifdef TC_READER_SYNC_WORD_EN
            sync_phase_reg <= 2'd0;
`endif
          end
        end

        S_ISSUE: begin
          lat_cnt_reg <= '0;
          state_reg   <= S_WAIT;
        end

        S_WAIT: begin
          if (lat_cnt_reg == LAT_LAST) begin
            tc_data   <= mem_rd_data;
            tc_valid  <= 1'b1;
`ifdef TC_READER_SYNC_WORD_EN
            tc_last   <= 1'b0;
`else
            tc_last   <= (index_reg == LAST_IDX);
`endif
            state_reg <= S_PRESENT;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 3'd1;
          end
        end

        S_PRESENT: begin
          // tc_valid is always high in this state
          if (tc_ready) begin
            tc_valid <= 1'b0;
            tc_last  <= 1'b0;
`ifdef TC_READER_SYNC_WORD_EN
            if (sync_phase_reg == 2'd0 && index_reg != LAST_IDX) begin
`else
            if (index_reg != LAST_IDX) begin
`endif
              index_reg <= index_reg + 8'd1;
              mem_addr  <= base_reg + ADDR_W'(index_reg + 8'd1);
              mem_rd_en <= 1'b1;
              state_reg <= S_ISSUE;
`ifdef TC_READER_SYNC_WORD_EN
            end else if (sync_phase_reg != 2'd2) begin
              sync_phase_reg <= sync_phase_reg + 2'd1;
              state_reg      <= S_GAP;
`endif
            end else begin
              busy      <= 1'b0;
              done      <= 1'b1;
              state_reg <= S_IDLE;
            end
          end
        end

`ifdef TC_READER_SYNC_WORD_EN
        // one idle cycle, then the sync byte selected by sync_phase_reg
        S_GAP: begin
          tc_data   <= (sync_phase_reg == 2'd1) ? SYNC_FIRST : SYNC_SECOND;
          tc_valid  <= 1'b1;
          tc_last   <= (sync_phase_reg == 2'd2);
          state_reg <= S_PRESENT;
        end
`endif

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timecode_memory_reader.sv
// Bench for timecode_memory_reader. Two instances: A (RD_LAT=1,
// FRAME_BYTES=10) and B (RD_LAT=3, FRAME_BYTES=4). Accepted starts push the
// expected read addresses and stream beats into per-instance queues; negedge
// monitors pop and compare them as the DUT produces reads and handshakes.

module tb_timecode_memory_reader;

  localparam int FB_A = 10;
  localparam int RD_A = 1;
  localparam int FB_B = 4;
  localparam int RD_B = 3;
`ifdef TC_READER_SYNC_WORD_EN
  localparam bit SYNC  = 1'b1;
  localparam int EXTRA = 4;
`else
  localparam bit SYNC  = 1'b0;
  localparam int EXTRA = 0;
`endif
  // start cycle = 0; done cycle relative to it
  localparam int DONE_A = (2 + RD_A) * FB_A + 1 + EXTRA;
  localparam int DONE_B = (2 + RD_B) * FB_B + 1 + EXTRA;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic        clk;
  logic        reset;
  int          cyc;
  int          n_checks;
  int          n_fail;
  int          done_cnt_a;
  int          done_cnt_b;

  logic        start_a, busy_a, done_a, en_a, valid_a, ready_a, last_a;
  logic [12:0] base_a, maddr_a;
  logic [7:0]  rdata_a, data_a;
  logic        start_b, busy_b, done_b, en_b, valid_b, ready_b, last_b;
  logic [12:0] base_b, maddr_b;
  logic [7:0]  rdata_b, data_b;
  logic [7:0]  pipe_b [0:2];

  logic [12:0] q_addr_a [$];
  logic [12:0] q_addr_b [$];
  beat_t       q_beat_a [$];
  beat_t       q_beat_b [$];

  timecode_memory_reader #(.ADDR_W(13), .DATA_W(8), .FRAME_BYTES(FB_A), .RD_LAT(RD_A)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .base_addr(base_a),
    .busy(busy_a), .done(done_a), .mem_rd_en(en_a), .mem_addr(maddr_a),
    .mem_rd_data(rdata_a), .tc_data(data_a), .tc_valid(valid_a),
    .tc_ready(ready_a), .tc_last(last_a)
  );

  timecode_memory_reader #(.ADDR_W(13), .DATA_W(8), .FRAME_BYTES(FB_B), .RD_LAT(RD_B)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .base_addr(base_b),
    .busy(busy_b), .done(done_b), .mem_rd_en(en_b), .mem_addr(maddr_b),
    .mem_rd_data(rdata_b), .tc_data(data_b), .tc_valid(valid_b),
    .tc_ready(ready_b), .tc_last(last_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory contents: 0x0100.. holds 0x00, 0x01, ...; other pages differ
  function automatic logic [7:0] mem_val(input logic [12:0] a);
    return a[7:0] + {3'b000, a[12:8]} - 8'd1;
  endfunction

  // memory models: data present only in the cycle RD_LAT after the strobe
  always @(posedge clk) rdata_a <= en_a ? mem_val(maddr_a) : 8'hEE;
  always @(posedge clk) begin
    pipe_b[0] <= en_b ? mem_val(maddr_b) : 8'hEE;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign rdata_b = pipe_b[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input bit which, input logic [12:0] base, input int fb);
    beat_t b;
    logic [12:0] a;
    for (int i = 0; i < fb; i++) begin
      a = base + 13'(i);
      b.data = mem_val(a);
      b.last = !SYNC && (i == fb - 1);
      if (which) begin q_addr_b.push_back(a); q_beat_b.push_back(b); end
      else       begin q_addr_a.push_back(a); q_beat_a.push_back(b); end
    end
    if (SYNC) begin
      for (int k = 0; k < 2; k++) begin
        b.data = (k == 0) ? 8'h3F : 8'hFD;
        b.last = (k == 1);
        if (which) q_beat_b.push_back(b);
        else       q_beat_a.push_back(b);
      end
    end
  endtask

  // called at posedge+1; leaves start high for exactly one cycle
  task automatic start_frame(input bit which, input logic [12:0] base, output int t0);
    if (which) begin start_b = 1'b1; base_b = base; end
    else       begin start_a = 1'b1; base_a = base; end
    push_frame(which, base, which ? FB_B : FB_A);
    t0 = cyc;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // returns at the negedge of the done cycle
  task automatic wait_done(input bit which, input string tag, input int budget, output int at);
    bit seen;
    seen = 1'b0;
    at = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if ((which ? done_b : done_a) === 1'b1) begin
        seen = 1'b1;
        at = cyc;
      end
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 1);
    if (seen) check_eq({tag, "_busy_at_done"}, 32'(which ? busy_b : busy_a), 0);
  endtask

  task automatic check_idle_a(input string tag);
    check_eq({tag, "_busy"}, 32'(busy_a), 0);
    check_eq({tag, "_done"}, 32'(done_a), 0);
    check_eq({tag, "_rd_en"}, 32'(en_a), 0);
    check_eq({tag, "_mem_addr"}, 32'(maddr_a), 0);
    check_eq({tag, "_tc_data"}, 32'(data_a), 0);
    check_eq({tag, "_tc_valid"}, 32'(valid_a), 0);
    check_eq({tag, "_tc_last"}, 32'(last_a), 0);
  endtask

  // scoreboard monitor, instance A
  always @(negedge clk) begin
    beat_t b;
    if (!reset) begin
      if (en_a) begin
        check_eq("a_rd_expected", 32'(q_addr_a.size() != 0), 1);
        if (q_addr_a.size() != 0) check_eq("a_mem_addr", 32'(maddr_a), 32'(q_addr_a.pop_front()));
      end
      if (valid_a && ready_a) begin
        check_eq("a_beat_expected", 32'(q_beat_a.size() != 0), 1);
        if (q_beat_a.size() != 0) begin
          b = q_beat_a.pop_front();
          check_eq("a_tc_data", 32'(data_a), 32'(b.data));
          check_eq("a_tc_last", 32'(last_a), 32'(b.last));
          $display("A beat data=0x%02h last=%0d cycle=%0d", data_a, last_a, cyc);
        end
      end
      if (done_a) done_cnt_a++;
    end
  end

  // scoreboard monitor, instance B, plus read-to-valid latency
  int en_cyc_b;
  bit pend_b;
  bit prev_valid_b;
  always @(negedge clk) begin
    beat_t b;
    if (!reset) begin
      if (en_b) begin
        check_eq("b_rd_expected", 32'(q_addr_b.size() != 0), 1);
        if (q_addr_b.size() != 0) check_eq("b_mem_addr", 32'(maddr_b), 32'(q_addr_b.pop_front()));
        en_cyc_b = cyc;
        pend_b = 1'b1;
      end
      if (valid_b && !prev_valid_b && pend_b) begin
        check_eq("b_valid_latency", 32'(cyc - en_cyc_b), RD_B + 1);
        pend_b = 1'b0;
      end
      if (valid_b && ready_b) begin
        check_eq("b_beat_expected", 32'(q_beat_b.size() != 0), 1);
        if (q_beat_b.size() != 0) begin
          b = q_beat_b.pop_front();
          check_eq("b_tc_data", 32'(data_b), 32'(b.data));
          check_eq("b_tc_last", 32'(last_b), 32'(b.last));
          $display("B beat data=0x%02h last=%0d cycle=%0d", data_b, last_b, cyc);
        end
      end
      if (done_b) done_cnt_b++;
    end
    prev_valid_b = valid_b;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0, t1, td;
    n_checks = 0; n_fail = 0; done_cnt_a = 0; done_cnt_b = 0;
    reset = 1'b1;
    start_a = 1'b0; base_a = '0; ready_a = 1'b1;
    start_b = 1'b0; base_b = '0; ready_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_a("rst");
    check_eq("rst_b_busy", 32'(busy_b), 0);
    check_eq("rst_b_valid", 32'(valid_b), 0);
    step();
    reset = 1'b0;

    // 1: basic frame, ready always high
    step();
    start_frame(1'b0, 13'h0100, t0);
    wait_done(1'b0, "t1", 200, td);
    check_eq("t1_done_cycle", 32'(td - t0), DONE_A);
    step();
    @(negedge clk);
    check_eq("t1_done_one_cycle", 32'(done_a), 0);
    check_eq("t1_busy_after", 32'(busy_a), 0);

    // 2: 5-cycle stall on byte 3
    step();
    start_frame(1'b0, 13'h0100, t0);
    repeat (11) step();
    ready_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t2_stall_valid", 32'(valid_a), 1);
      check_eq("t2_stall_data", 32'(data_a), 32'h03);
      check_eq("t2_stall_last", 32'(last_a), 0);
      check_eq("t2_stall_no_rd", 32'(en_a), 0);
      step();
    end
    ready_a = 1'b1;
    wait_done(1'b0, "t2", 200, td);
    check_eq("t2_done_cycle", 32'(td - t0), DONE_A + 5);

    // 4: start while busy is ignored; start in the done cycle is accepted
    step();
    start_frame(1'b0, 13'h0100, t0);
    repeat (5) step();
    start_a = 1'b1;
    base_a = 13'h0500;
    @(negedge clk);
    check_eq("t4_busy_mid", 32'(busy_a), 1);
    step();
    start_a = 1'b0;
    repeat (DONE_A - 7) step();
    start_a = 1'b1;
    base_a = 13'h0200;
    push_frame(1'b0, 13'h0200, FB_A);
    t1 = cyc;
    @(negedge clk);
    check_eq("t4_done_cycle_pulse", 32'(done_a), 1);
    check_eq("t4_done_cycle_busy", 32'(busy_a), 0);
    step();
    start_a = 1'b0;
    wait_done(1'b0, "t4b", 200, td);
    check_eq("t4_second_done_cycle", 32'(td - t1), DONE_A);

    // 5: reset during WAIT of byte 4
    step();
    start_frame(1'b0, 13'h0300, t0);
    repeat (13) step();
    @(negedge clk);
    check_eq("t5_wait_no_rd", 32'(en_a), 0);
    check_eq("t5_wait_busy", 32'(busy_a), 1);
    reset = 1'b1;
    step();
    @(negedge clk);
    check_idle_a("t5_rst");
    step();
    reset = 1'b0;
    q_addr_a.delete();
    q_beat_a.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t5_no_done", 32'(done_a), 0);
      check_eq("t5_idle_busy", 32'(busy_a), 0);
      step();
    end
    start_frame(1'b0, 13'h0300, t0);
    wait_done(1'b0, "t5", 200, td);
    check_eq("t5_done_cycle", 32'(td - t0), DONE_A);

    // 6: instance B, RD_LAT=3, address wrap at 0x1FFE
    step();
    start_frame(1'b1, 13'h1FFE, t0);
    wait_done(1'b1, "t6", 300, td);
    check_eq("t6_done_cycle", 32'(td - t0), DONE_B);

    step();
    @(negedge clk);
    check_eq("end_addr_q_a", 32'(q_addr_a.size()), 0);
    check_eq("end_beat_q_a", 32'(q_beat_a.size()), 0);
    check_eq("end_addr_q_b", 32'(q_addr_b.size()), 0);
    check_eq("end_beat_q_b", 32'(q_beat_b.size()), 0);
    check_eq("end_done_cnt_a", 32'(done_cnt_a), 5);
    check_eq("end_done_cnt_b", 32'(done_cnt_b), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timecode_memory_reader.md
Name: timecode_memory_reader

Overview:
- Read-side counterpart of the timecode write path.
- On a start request, fetches one timecode frame of FRAME_BYTES consecutive bytes from the timecode memory, beginning at base_addr.
- Presents the bytes in order on a valid/ready byte stream for the downstream LTC serializer, and marks the final byte with tc_last.
- Issues one memory read at a time, so memory read latency and stream backpressure never overlap.

Parameters:
ADDR_W, 13, memory address width
DATA_W, 8, memory/stream data width
FRAME_BYTES, 10, bytes per timecode frame (legal range 1..255)
RD_LAT, 1, memory read latency in cycles (legal range 1..4)

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
start  in  1  one-cycle request to read a frame; honoured only when busy=0
base_addr  in  ADDR_W  first frame address; sampled on an accepted start
busy  out  1  frame read in progress
done  out  1  one-cycle pulse after the final byte handshake
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_W  memory read address
mem_rd_data  in  DATA_W  memory read data; valid RD_LAT cycles after the mem_rd_en cycle
tc_data  out  DATA_W  stream byte
tc_valid  out  1  stream byte valid
tc_ready  in  1  downstream accepts byte
tc_last  out  1  final byte of frame; qualified by tc_valid

Behaviour:
- All outputs are registered. Reset is: reset synchronous, active-high; clock clk.
- Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, tc_data=0, tc_valid=0, tc_last=0, state=IDLE, byte index=0.
- State machine:
  - IDLE: start=1 latches base_addr, clears the byte index, sets busy=1 and moves to ISSUE.
  - ISSUE (1 cycle): mem_rd_en=1 and mem_addr=(base_addr+index) mod 2^ADDR_W. Moves to WAIT.
  - WAIT (RD_LAT cycles): the latency counter counts RD_LAT cycles after the ISSUE cycle. At the clock edge ending the last WAIT cycle, mem_rd_data is captured into tc_data. tc_valid=1 and tc_last=(index==FRAME_BYTES-1) from the next cycle. Moves to PRESENT.
  - PRESENT: tc_valid, tc_data and tc_last hold stable until tc_valid&tc_ready. On the handshake, tc_valid and tc_last clear.
    - If bytes remain: index increments and the block moves to ISSUE in the next cycle.
    - Otherwise: the block moves to IDLE, done=1 for one cycle, and busy=0 in that same cycle.
- mem_rd_en is high only in ISSUE. mem_addr holds its last value otherwise.
- Latency with RD_LAT=1 and tc_ready held high:
  - start sampled at the end of cycle 0.
  - ISSUE in cycle 1, WAIT in cycle 2, first tc_valid in cycle 3.
  - 3 cycles per byte.
  - For FRAME_BYTES=10, done is high in cycle 31.
- Address wrap: the sum wraps modulo 2^ADDR_W with no error. Example: base 0x1FFE reads 0x1FFE, 0x1FFF, 0x0000, and so on.
- start while busy=1 is ignored. No queuing, and the latched base_addr is unchanged.
- start in the done cycle is accepted, because busy=0 in that cycle.
- tc_ready while tc_valid=0 has no effect.
- Reset mid-frame aborts immediately to the reset values. No done pulse is generated and the partial frame is discarded.

Optional Feature:
- Macro TC_READER_SYNC_WORD_EN.
- Defined:
  - After the last memory byte, the block presents two extra stream bytes, 0x3F then 0xFD (the LTC sync word). No memory reads are issued for these bytes.
  - Each sync byte is presented in PRESENT directly after the previous handshake, with a 1-cycle gap.
  - tc_last is asserted on 0xFD only. The frame is FRAME_BYTES+2 beats.
  - done pulses after the 0xFD handshake.
- Undefined: the frame is FRAME_BYTES beats, and tc_last is on the last memory byte.

Test Plan:
- Memory preloaded with 0x00..0x09 at 0x0100; start with base_addr=0x0100, tc_ready=1 -> mem_addr 0x0100..0x0109 in order; stream bytes 0x00..0x09; tc_last only on 0x09; done in cycle 31; busy low afterwards.
- Same frame with tc_ready low for 5 cycles on byte 3 -> tc_data=0x03 and tc_valid held stable; no mem_rd_en during the stall; stream order intact.
- base_addr=0x1FFE, FRAME_BYTES=4 -> addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- Second start pulse mid-frame with base_addr=0x0500 -> ignored; frame completes from the original base; start in the done cycle begins a new frame.
- Reset asserted while in WAIT on byte 4 -> next cycle all outputs are 0 and busy=0; no done pulse; a fresh start works normally.
- RD_LAT=3 -> tc_valid rises 4 cycles after each mem_rd_en cycle; with the macro defined, the stream ends 0x3F, 0xFD with tc_last on 0xFD.
